// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b types for the cache/memory arbitration path.
package lc3b_types;
   localparam int LC3B_LINE_WIDTH = 128;
   typedef logic [15:0] lc3b_word;
   typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_cache_line;
   typedef enum logic {ARB_I = 1'b0, ARB_D = 1'b1} lc3b_arb_sel;
endpackage

// File: rtl/arbiter_rr_pick.sv
// arbiter_rr_pick: two-way round-robin pick; on a tie the requester that did not win last time gets it.
module arbiter_rr_pick
   import lc3b_types::*;
(
   input  logic        req_i,
   input  logic        req_d,
   input  lc3b_arb_sel last_grant,
   output logic        grant_valid,
   output lc3b_arb_sel grant_sel
);
   always_comb begin
      grant_valid = req_i | req_d;
      grant_sel = (req_i & req_d) ? ((last_grant == ARB_I) ? ARB_D : ARB_I)
                                  : (req_d ? ARB_D : ARB_I);
   end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one pmem port between I-cache and D-cache, one grant per transaction,
// with a dead release cycle after each response so the served cache can drop its request.
module cache_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_pmem_read,
   input  logic                  i_pmem_write,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);
   typedef enum logic [1:0] {s_idle, s_serve_i, s_serve_d, s_release} state_t;
   state_t                state_q, state_d;
   lc3b_arb_sel           last_grant_q, last_grant_d, grant_sel;
   logic                  grant_valid, req_i, req_d, serving;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   assign req_i = i_pmem_read | i_pmem_write;
   assign req_d = d_pmem_read | d_pmem_write;
   arbiter_rr_pick u_pick (
      .req_i       (req_i),
      .req_d       (req_d),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_sel   (grant_sel)
   );
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      case (state_q)
         s_idle: if (grant_valid) begin
            state_d = (grant_sel == ARB_D) ? s_serve_d : s_serve_i;
            if (req_i && req_d) last_grant_d = grant_sel;
            addr_d  = (grant_sel == ARB_D) ? d_pmem_address : i_pmem_address;
            wdata_d = (grant_sel == ARB_D) ? d_pmem_wdata : i_pmem_wdata;
            write_d = (grant_sel == ARB_D) ? d_pmem_write : i_pmem_write;
         end
         s_serve_i, s_serve_d: if (pmem_resp) state_d = s_release;
         default: state_d = s_idle;
      endcase
   end
   // Latched op drives memory, so a request dropped mid-transaction still completes.
   assign serving      = (state_q == s_serve_i) || (state_q == s_serve_d);
   assign pmem_read    = serving & ~write_q;
   assign pmem_write   = serving & write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign i_pmem_resp  = (state_q == s_serve_i) & pmem_resp;
   assign d_pmem_resp  = (state_q == s_serve_d) & pmem_resp;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= s_idle;
         last_grant_q <= ARB_I;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
      end
   end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;
   logic         clk = 1'b0;
   logic         reset;
   logic         i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
   logic [15:0]  i_pmem_address, d_pmem_address, pmem_address;
   logic [127:0] i_pmem_wdata, d_pmem_wdata, i_pmem_rdata, d_pmem_rdata;
   logic         i_pmem_resp, d_pmem_resp, pmem_read, pmem_write, pmem_resp;
   logic [127:0] pmem_wdata, pmem_rdata;
   int           checks = 0;
   int           errors = 0;
   localparam logic [127:0] LINE_A = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
   localparam logic [127:0] LINE_B = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;
   localparam logic [127:0] LINE_W = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
   localparam logic [127:0] LINE_5 = {32{4'h5}};

   cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
      .clk(clk), .reset(reset),
      .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
      .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ":strobes"}, {pmem_read, pmem_write}, 2'b00);
      chk({tag, ":resps"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
   endtask

   // Entered in the first serve cycle; leaves in the idle cycle following release.
   task automatic serve(input string tag, input logic d, input logic wr, input logic [15:0] a,
                        input logic [127:0] wd, input int wait_n, input logic [127:0] rd);
      chk({tag, ":read"}, pmem_read, !wr);
      chk({tag, ":write"}, pmem_write, wr);
      chk({tag, ":addr"}, pmem_address, a);
      if (wr) chk({tag, ":wdata"}, pmem_wdata, wd);
      repeat (wait_n) begin
         chk({tag, ":early_resp"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
         tick();
      end
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      #1;
      chk({tag, ":i_resp"}, i_pmem_resp, !d);
      chk({tag, ":d_resp"}, d_pmem_resp, d);
      chk({tag, ":i_rdata"}, i_pmem_rdata, rd);
      chk({tag, ":d_rdata"}, d_pmem_rdata, rd);
      if (d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      else begin i_pmem_read = 1'b0; i_pmem_write = 1'b0; end
      tick();
      chk_idle_outputs({tag, ":release"});
      pmem_resp = 1'b0;
      tick();
      chk_idle_outputs({tag, ":idle"});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      {i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write, pmem_resp} = '0;
      {i_pmem_address, d_pmem_address} = '0;
      {i_pmem_wdata, d_pmem_wdata, pmem_rdata} = '0;
      reset = 1'b1;
      tick();
      do_reset();
      chk_idle_outputs("reset");
      chk("reset:addr", pmem_address, 16'h0);
      chk("reset:wdata", pmem_wdata, 128'h0);
      chk("reset:rdata", {i_pmem_rdata, d_pmem_rdata}, 256'h0);

      i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
      #1;
      chk("i_only:cycleN", pmem_read, 1'b0);
      tick();
      serve("i_only", 1'b0, 1'b0, 16'h1230, '0, 3, LINE_A);

      i_pmem_read = 1'b1; i_pmem_address = 16'h0040;
      d_pmem_write = 1'b1; d_pmem_address = 16'h8000; d_pmem_wdata = LINE_W;
      tick();
      serve("tie1_d", 1'b1, 1'b1, 16'h8000, LINE_W, 1, LINE_B);
      tick();
      serve("tie1_i", 1'b0, 1'b0, 16'h0040, '0, 0, LINE_A);
      i_pmem_read = 1'b1; i_pmem_address = 16'h0044;
      d_pmem_read = 1'b1; d_pmem_address = 16'h9000;
      tick();
      serve("tie2_i", 1'b0, 1'b0, 16'h0044, '0, 2, LINE_B);
      tick();
      serve("tie2_d", 1'b1, 1'b0, 16'h9000, '0, 0, LINE_A);

      pmem_resp = 1'b1;
      #1;
      chk_idle_outputs("spur_idle");
      tick();
      chk_idle_outputs("spur_idle2");
      pmem_resp = 1'b0;

      do_reset();
      i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
      d_pmem_write = 1'b1; d_pmem_address = 16'h2000; d_pmem_wdata = LINE_W;
      tick();
      serve("wb_d", 1'b1, 1'b1, 16'h2000, LINE_W, 1, LINE_B);
      d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
      tick();
      serve("wb_i", 1'b0, 1'b0, 16'h0100, '0, 1, LINE_A);
      tick();
      serve("wb_rep", 1'b1, 1'b0, 16'h2000, '0, 1, LINE_B);

      d_pmem_write = 1'b1; d_pmem_address = 16'hA000; d_pmem_wdata = LINE_W;
      tick();
      chk("rst_mid:write", pmem_write, 1'b1);
      pmem_resp = 1'b1; d_pmem_write = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk_idle_outputs("rst_mid");
      chk("rst_mid:addr", pmem_address, 16'h0);
      chk("rst_mid:wdata", pmem_wdata, 128'h0);
      pmem_resp = 1'b0;
      i_pmem_read = 1'b1; i_pmem_address = 16'h0200;
      d_pmem_read = 1'b1; d_pmem_address = 16'h0300;
      tick();
      serve("post_rst_d", 1'b1, 1'b0, 16'h0300, '0, 0, LINE_A);
      tick();
      serve("post_rst_i", 1'b0, 1'b0, 16'h0200, '0, 0, LINE_B);

      i_pmem_read = 1'b1; i_pmem_write = 1'b1; i_pmem_address = 16'h3000; i_pmem_wdata = LINE_5;
      tick();
      serve("rw_as_w", 1'b0, 1'b1, 16'h3000, LINE_5, 1, LINE_A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
